// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle RV32I-subset core with a unified ready-handshake memory port, halt on illegal opcode and retired-instruction counter
module mc_cpu_core #(
  parameter int AW = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic [31:0]   instret,
  output logic [AW-1:0] debug_pc,
  input  logic [4:0]    debug_rf_addr,
  output logic [31:0]   debug_rf_data,
  output logic [2:0]    debug_state
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LW = 7'h03, OP_SW = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  logic [2:0] state;
  logic [AW-1:0] pc, pc4, pc_imm, br_tgt, nxt_pc;
  logic [31:0] ir, a, b, imm, alu_out, mdr, alu, imm_dec;
  logic [31:0] rf [32];
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd;
  logic legal, is_jump, taken;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign rd = ir[11:7];
  assign legal = op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
  assign is_jump = op == OP_JAL || op == OP_JALR;
  assign imm_dec = op == OP_SW ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
                 : op == OP_BR ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
                 : op == OP_JAL ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}
                 : {{20{ir[31]}}, ir[31:20]};
  assign alu = op != OP_R ? a + imm
             : f3 == 3'd7 ? a & b
             : f3 == 3'd6 ? a | b
             : ir[30] ? a - b : a + b;
  assign taken = f3 == 3'd4 ? $signed(a) < $signed(b) : a == b;
  assign pc4 = pc + AW'(4);
  assign pc_imm = pc + imm[AW-1:0];
  assign br_tgt = taken ? pc_imm : pc4;
  assign nxt_pc = op == OP_BR ? br_tgt : op == OP_JAL ? pc_imm : op == OP_JALR ? alu[AW-1:0] : pc;
  // Gated by rstn so the request drops the moment reset asserts, not at the next edge
  assign mem_req = rstn && (state == FETCH || state == MEM);
  assign mem_we = rstn && state == MEM && op == OP_SW;
  assign mem_addr = state == MEM ? {alu_out[AW-1:2], 2'b00} : pc;
  assign mem_wdata = b;
  assign halted = state == HALT;
  assign debug_pc = pc;
  assign debug_state = state;
  assign debug_rf_data = rf[debug_rf_addr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      imm <= '0;
      alu_out <= '0;
      mdr <= '0;
      instret <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          state <= DECODE;
        end
        DECODE: begin
          a <= rf[ir[19:15]];
          b <= rf[ir[24:20]];
          imm <= imm_dec;
          state <= legal ? EXEC : HALT;
        end
        EXEC: begin
          alu_out <= is_jump ? {{(32-AW){1'b0}}, pc4} : alu;
          pc <= {nxt_pc[AW-1:2], 2'b00};
          instret <= instret + {31'd0, op == OP_BR};
          state <= op == OP_BR ? FETCH : (op == OP_LW || op == OP_SW) ? MEM : WB;
        end
        MEM: if (mem_ready) begin
          if (op == OP_SW) begin
            pc <= pc4;
            instret <= instret + 32'd1;
            state <= FETCH;
          end else begin
            mdr <= mem_rdata;
            state <= WB;
          end
        end
        WB: begin
          if (rd != 5'd0) rf[rd] <= op == OP_LW ? mdr : alu_out;
          if (!is_jump) pc <= pc4;
          instret <= instret + 32'd1;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
endmodule
